ps2_rx_buffered: RTL and testbench

PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_fifo.sv | 52 +++++
 rtl/ps2_filter.sv | 58 +++++
 rtl/ps2_rx_buffered.sv | 153 +++++++++++++++
 tb/tb_ps2_rx_buffered.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receiver
// Purpose: receiver state encoding, frame geometry and err_flags bit positions.
// Ports: none (package).
package ps2_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // err_flags bit positions: {overflow, frame_err, parity_err}
    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;
    localparam int ERR_OVF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - received-byte queue
// Purpose: power-of-two circular buffer; push is refused when full unless a pop
//          happens in the same cycle; pops on an empty queue are ignored.
// Ports: clk, reset (sync active-low), push_i/data_i (write), pop_i (read),
//        rd_data_o (oldest entry, 0 when empty), count_o, full_o, empty_o.
module ps2_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - synchronizer, glitch filter and falling-edge detector for one PS/2 line
// Purpose: double-registers an asynchronous line, accepts a level change only after
//          FILTER_LEN consecutive identical synchronized samples, flags falling edges.
// Ports: clk, reset (sync active-low), line_i (async line),
//        level_o (filtered level), fall_o (one-cycle pulse on filtered 1->0).
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx_buffered.sv
// rtl/ps2_rx_buffered.sv - buffered PS/2 frame receiver
// Purpose: receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop),
//          queues good bytes, reports sticky overflow/frame/parity errors and
//          aborts stalled frames after TIMEOUT_CYCLES without a clock edge.
// Config macro: PS2_RX_PARITY_CHK_EN - defined: bad parity discards the byte and sets
//               err_flags[0]; undefined: parity bit is sampled but ignored.
// Ports: clk, reset (sync active-low), ps2c/ps2d (async PS/2 lines), rx_en (start enable),
//        rx_ready/rx_valid/rx_data (byte output handshake), rx_done_tick (good frame pulse),
//        fifo_count (occupancy), err_flags {overflow, frame_err, parity_err}, err_clr.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2c,
    input  logic                        ps2d,
    input  logic                        rx_en,
    input  logic                        rx_ready,
    output logic                        rx_valid,
    output logic [7:0]                  rx_data,
    output logic                        rx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [2:0]                  err_flags,
    input  logic                        err_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic c_level, c_fall, d_level, d_fall;
    logic unused_ok;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk(clk), .reset(reset), .line_i(ps2c), .level_o(c_level), .fall_o(c_fall)
    );
    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk(clk), .reset(reset), .line_i(ps2d), .level_o(d_level), .fall_o(d_fall)
    );

    rx_state_e           state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                done_q, good_d;
    logic [2:0]          err_q, err_d;
    logic                frame_err_set, par_err_set, ovf_set, parity_bad;
    logic                fifo_full, fifo_empty, pop;

    assign unused_ok = &{1'b0, c_level, d_fall, par_q};

`ifdef PS2_RX_PARITY_CHK_EN
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign parity_bad = ~(^shift_q ^ par_q);
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        tmo_d         = tmo_q;
        good_d        = 1'b0;
        frame_err_set = 1'b0;
        par_err_set   = 1'b0;

        // Stall watchdog only runs mid-frame and restarts on every clock edge.
        if (state_q == ST_IDLE || c_fall) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d         = '0;
            state_d       = ST_IDLE;
            frame_err_set = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (c_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!d_level && rx_en) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {d_level, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = d_level;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (!d_level)        frame_err_set = 1'b1;
                    else if (parity_bad) par_err_set   = 1'b1;
                    else                 good_d        = 1'b1;
                end
            endcase
        end
    end

    assign pop     = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign ovf_set = good_d && fifo_full && !pop;

    // Error sets override a same-cycle clear.
    always_comb begin
        err_d = err_clr ? 3'b000 : err_q;
        if (ovf_set)       err_d[ERR_OVF]    = 1'b1;
        if (frame_err_set) err_d[ERR_FRAME]  = 1'b1;
        if (par_err_set)   err_d[ERR_PARITY] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            done_q    <= good_d;
            err_q     <= err_d;
        end
    end

    ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
        .clk(clk), .reset(reset),
        .push_i(good_d), .data_i(shift_q), .pop_i(pop),
        .rd_data_o(rx_data), .count_o(fifo_count),
        .full_o(fifo_full), .empty_o(fifo_empty)
    );

    assign rx_valid     = !fifo_empty;
    assign rx_done_tick = done_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// tb/tb_ps2_rx_buffered.sv - self-checking bench for ps2_rx_buffered
module tb_ps2_rx_buffered;

    localparam int TMO   = 2000;
    localparam int DEPTH = 16;
    localparam int H     = 20;
`ifdef PS2_RX_PARITY_CHK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ps2c = 1'b1, ps2d = 1'b1, rx_en = 1'b0, rx_ready = 1'b0, err_clr = 1'b0;
    logic       rx_valid, rx_done_tick;
    logic [7:0] rx_data;
    logic [4:0] fifo_count;
    logic [2:0] err_flags;

    int total = 0, passed = 0, done_cnt = 0, exp_done = 0;
    logic [7:0] got_q[$], exp_q[$];
    logic [2:0] exp_err = 3'b000;

    ps2_rx_buffered #(.FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(rst_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_done_tick(rx_done_tick), .fifo_count(fifo_count),
        .err_flags(err_flags), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rst_n && rx_done_tick) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Reference: what a receiver must do with one complete frame.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        if (!stop) exp_err[1] = 1'b1;
        else if (PAR_ON && par != odd_par(b)) exp_err[0] = 1'b1;
        else begin
            exp_done++;
            if (exp_q.size() < DEPTH || rx_ready) exp_q.push_back(b);
            else exp_err[2] = 1'b1;
        end
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits, input int en_off_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == en_off_at) rx_en = 1'b0;
            ps2d = frame[i];
            cyc(H);
            ps2c = 1'b0;
            cyc(H);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        cyc(3 * H);
    endtask

    task automatic send(input logic [7:0] b, input logic par, input logic stop);
        model_frame(b, par, stop);
        send_bits({stop, par, b, 1'b0}, 11, -1);
    endtask

    task automatic drain_check(input string tag);
        int n;
        rx_ready = 1'b1;
        n = 0;
        while (fifo_count != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < 200), 1);
        rx_ready = 1'b0;
        cyc(2);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        exp_err = 3'b000;
        check("err_clr", err_flags, exp_err);
    endtask

    initial begin
        logic [7:0] b;
        logic       p, s;

        cyc(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_done", rx_done_tick, 0);
        check("rst_count", fifo_count, 0);
        check("rst_err", err_flags, 0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        cyc(5);

        // 0x5A with correct odd parity, consumer ready
        rx_ready = 1'b1;
        send(8'h5A, 1'b1, 1'b1);
        check("x5a_done", done_cnt, exp_done);
        check("x5a_err", err_flags, exp_err);
        drain_check("x5a");

        // random good bytes streamed out
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send(b, odd_par(b), 1'b1);
        end
        check("rand_done", done_cnt, exp_done);
        check("rand_err", err_flags, exp_err);
        drain_check("rand");

        // 0x3C with wrong parity bit
        send(8'h3C, ~odd_par(8'h3C), 1'b1);
        check("bad_par_err", err_flags, exp_err);
        check("bad_par_done", done_cnt, exp_done);
        drain_check("bad_par");
        clear_err();

        // stop bit low
        b = 8'($urandom);
        send(b, odd_par(b), 1'b0);
        check("stop0_err", err_flags, exp_err);
        check("stop0_done", done_cnt, exp_done);
        drain_check("stop0");
        clear_err();

        // overflow: 17 frames into a 16-entry queue with no consumer
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send(b, odd_par(b), 1'b1);
        end
        check("ovf_count", fifo_count, exp_q.size());
        check("ovf_err", err_flags, exp_err);
        check("ovf_done", done_cnt, exp_done);
        drain_check("ovf");
        clear_err();

        // stalled frame: 4 bits then silence past the timeout
        send_bits({2'b11, 8'h0F, 1'b0}, 4, -1);
        cyc(TMO + 50);
        exp_err[1] = 1'b1;
        check("tmo_err", err_flags, exp_err);
        send(8'hA5, odd_par(8'hA5), 1'b1);
        check("tmo_next_done", done_cnt, exp_done);
        drain_check("tmo_next");
        clear_err();

        // 3-cycle glitch on ps2c while idle must not start a frame
        ps2d = 1'b0;
        cyc(H);
        ps2c = 1'b0;
        cyc(3);
        ps2c = 1'b1;
        cyc(2 * H);
        ps2d = 1'b1;
        cyc(H);
        check("glitch_done", done_cnt, exp_done);
        send(8'h81, odd_par(8'h81), 1'b1);
        check("glitch_err", err_flags, exp_err);
        drain_check("glitch");

        // rx_en low blocks starts; dropping it mid-frame lets the frame finish
        rx_en = 1'b0;
        send_bits({2'b11, 8'h77, 1'b0}, 11, -1);
        check("en_off_count", fifo_count, 0);
        check("en_off_done", done_cnt, exp_done);
        rx_en = 1'b1;
        model_frame(8'h6B, odd_par(8'h6B), 1'b1);
        send_bits({1'b1, odd_par(8'h6B), 8'h6B, 1'b0}, 11, 3);
        rx_en = 1'b1;
        check("en_mid_done", done_cnt, exp_done);
        drain_check("en_mid");

        // random mix of good, bad-parity and bad-stop frames
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~odd_par(b) : odd_par(b);
            s = ($urandom_range(0, 9) != 0);
            send(b, p, s);
        end
        check("mix_err", err_flags, exp_err);
        check("mix_done", done_cnt, exp_done);
        drain_check("mix");
        clear_err();

        // reset in the middle of a frame with data and errors present
        rx_ready = 1'b0;
        send(8'h42, odd_par(8'h42), 1'b1);
        send(8'h11, odd_par(8'h11), 1'b0);
        send_bits({2'b11, 8'hFF, 1'b0}, 5, -1);
        rst_n = 1'b0;
        cyc(1);
        check("mrst_valid", rx_valid, 0);
        check("mrst_data", rx_data, 0);
        check("mrst_done", rx_done_tick, 0);
        check("mrst_count", fifo_count, 0);
        check("mrst_err", err_flags, 0);
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        exp_err = 3'b000;
        cyc(5);
        send(8'h5A, odd_par(8'h5A), 1'b1);
        check("post_rst_err", err_flags, exp_err);
        drain_check("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
